// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// The state encoding, default sizes and error-counter limits live here so every tdm_demux file agrees on them.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  localparam int                ERR_W   = 8;
  localparam logic [ERR_W-1:0]  ERR_MAX = 8'hFF;

endpackage

// File: rtl/tdm_demux_seq.sv
// Frame-alignment sequencer for tdm_demux: tracks HUNT/LOCK and the expected channel index.
// It emits a same-cycle write decision plus frame_done/sync_err events; the top level registers them.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   HUNT  | not aligned; discard beats until one carries in_sof
//   LOCK  | aligned; ch_idx is the channel expected on the next beat
module tdm_demux_seq
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          frame_done,
  output logic          sync_err
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] ch_idx, ch_idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      ch_idx <= '0;
    end else begin
      state  <= state_nxt;
      ch_idx <= ch_idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_idx_nxt = ch_idx;
    wr_en      = 1'b0;
    wr_idx     = ch_idx;
    frame_done = 1'b0;
    sync_err   = 1'b0;

    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            ch_idx_nxt = IW'(1);
            state_nxt  = LOCK;
          end
        end
        LOCK: begin
          if (in_sof) begin
            // An early sof abandons the partial frame but is still a valid channel 0.
            sync_err   = (ch_idx != '0);
            wr_en      = 1'b1;
            wr_idx     = '0;
            ch_idx_nxt = IW'(1);
          end else if (ch_idx == '0) begin
            sync_err   = 1'b1;
            ch_idx_nxt = '0;
            state_nxt  = HUNT;
          end else begin
            wr_en  = 1'b1;
            wr_idx = ch_idx;
            if (ch_idx == LAST_IDX) begin
              frame_done = 1'b1;
              ch_idx_nxt = '0;
            end else begin
              ch_idx_nxt = ch_idx + IW'(1);
            end
          end
        end
        default: begin
          state_nxt  = HUNT;
          ch_idx_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: spreads a framed serial sample stream round-robin over N_CH registered outputs.
// Define TDM_DEMUX_FRAME_BUF_EN to stage samples in a shadow buffer and publish whole frames atomically.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int IW = $clog2(N_CH);

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          frame_end;
  logic          err_hit;

  logic [N_CH-1:0][W-1:0] chan_q;

  tdm_demux_seq #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .frame_done (frame_end),
    .sync_err   (err_hit)
  );

  assign out_data = chan_q;

`ifdef TDM_DEMUX_FRAME_BUF_EN
  logic [N_CH-1:0][W-1:0] shadow_q;
  logic [N_CH-1:0][W-1:0] frame_next;

  // The final sample is merged in here so the publish happens on the same edge it arrives.
  always_comb begin
    frame_next = shadow_q;
    if (wr_en) begin
      frame_next[wr_idx] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      chan_q    <= '0;
      out_valid <= '0;
    end else begin
      out_valid <= '0;
      if (wr_en) begin
        shadow_q <= frame_next;
      end
      if (frame_end) begin
        chan_q    <= frame_next;
        out_valid <= '1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q    <= '0;
      out_valid <= '0;
    end else begin
      out_valid <= '0;
      if (wr_en) begin
        chan_q[wr_idx]    <= in_data;
        out_valid[wr_idx] <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= frame_end;
      sync_err   <= err_hit;
      if (err_hit && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random beats against a frame-level reference model.
// The model tracks "which channel comes next" as a plain integer position and rebuilds every output each cycle.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              sync_err;
  logic [7:0]        err_cnt;

  int checks   = 0;
  int failures = 0;

  int           m_pos;
  logic [W-1:0] m_chan   [N_CH];
  logic [W-1:0] m_shadow [N_CH];
  int           m_err;
  logic [N_CH-1:0] e_valid;
  logic            e_fd;
  logic            e_se;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = -1;
    m_err = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_chan[k]   = '0;
      m_shadow[k] = '0;
    end
    e_valid = '0;
    e_fd    = 1'b0;
    e_se    = 1'b0;
  endtask

  task automatic model_write(input int k, input logic [W-1:0] d, input bit last);
`ifdef TDM_DEMUX_FRAME_BUF_EN
    m_shadow[k] = d;
    if (last) begin
      for (int j = 0; j < N_CH; j++) m_chan[j] = m_shadow[j];
      e_valid = '1;
    end
`else
    m_chan[k]  = d;
    e_valid[k] = 1'b1;
`endif
  endtask

  task automatic model_error();
    e_se = 1'b1;
    if (m_err < 255) m_err++;
  endtask

  // m_pos < 0 means unaligned; otherwise it is the channel the next beat should carry.
  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    bit last;
    e_valid = '0;
    e_fd    = 1'b0;
    e_se    = 1'b0;
    if (v) begin
      if (m_pos < 0) begin
        if (s) begin
          model_write(0, d, 1'b0);
          m_pos = 1;
        end
      end else if (s) begin
        if (m_pos != 0) model_error();
        model_write(0, d, 1'b0);
        m_pos = 1;
      end else if (m_pos == 0) begin
        model_error();
        m_pos = -1;
      end else begin
        last = (m_pos == N_CH - 1);
        model_write(m_pos, d, last);
        e_fd  = last;
        m_pos = last ? 0 : m_pos + 1;
      end
    end
  endtask

  function automatic logic [N_CH*W-1:0] model_word();
    logic [N_CH*W-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*W +: W] = m_chan[k];
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".out_data"},   64'(out_data),   64'(model_word()));
    check({tag, ".out_valid"},  64'(out_valid),  64'(e_valid));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(e_fd));
    check({tag, ".sync_err"},   64'(sync_err),   64'(e_se));
    check({tag, ".err_cnt"},    64'(err_cnt),    64'(m_err));
  endtask

  task automatic beat(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b0;

    beat("hunt0", 1'b1, 1'b0, 8'hAA);
    beat("hunt1", 1'b1, 1'b0, 8'hBB);
    check("hunt_word", 64'(out_data), 64'h0);

    beat("nf0", 1'b1, 1'b1, 8'h11);
    beat("nf1", 1'b1, 1'b0, 8'h22);
    beat("nf2", 1'b1, 1'b0, 8'h33);
    beat("nf3", 1'b1, 1'b0, 8'h44);
    check("nf_word", 64'(out_data), 64'h4433_2211);
    beat("nf_idle", 1'b0, 1'b0, 8'h00);

    beat("es0", 1'b1, 1'b1, 8'h05);
    beat("es1", 1'b1, 1'b0, 8'h01);
    beat("es2", 1'b1, 1'b0, 8'h02);
    beat("es3", 1'b1, 1'b1, 8'h09);
    check("es_err_cnt", 64'(err_cnt), 64'd1);
    beat("es4", 1'b1, 1'b0, 8'h0A);
    beat("es5", 1'b1, 1'b0, 8'h0B);
    beat("es6", 1'b1, 1'b0, 8'h0C);

    beat("ms0", 1'b1, 1'b0, 8'h55);
    beat("ms1", 1'b1, 1'b0, 8'h66);

    beat("gap0", 1'b1, 1'b1, 8'hC0);
    beat("gap1", 1'b0, 1'b1, 8'hEE);
    beat("gap2", 1'b1, 1'b0, 8'hC1);
    beat("gap3", 1'b0, 1'b0, 8'hEF);
    beat("gap4", 1'b0, 1'b0, 8'hEF);
    beat("gap5", 1'b1, 1'b0, 8'hC2);
    beat("gap6", 1'b1, 1'b0, 8'hC3);

    beat("mid0", 1'b1, 1'b1, 8'h71);
    beat("mid1", 1'b1, 1'b0, 8'h72);
    async_reset("mid_rst");
    beat("mid2", 1'b1, 1'b0, 8'h73);
    beat("mid3", 1'b1, 1'b1, 8'h74);

    for (int i = 0; i < 400; i++) begin
      logic v, s;
      v = ($urandom % 5) != 0;
      s = ($urandom % 6) == 0;
      beat("rnd", v, s, W'($urandom));
      if (i == 200) async_reset("rnd_rst");
    end

    for (int i = 0; i < 300; i++) begin
      beat("sat_sof", 1'b1, 1'b1, W'($urandom));
      for (int k = 1; k < N_CH; k++) beat("sat_ch", 1'b1, 1'b0, W'($urandom));
      beat("sat_miss", 1'b1, 1'b0, W'($urandom));
    end
    check("sat_err_cnt", 64'(err_cnt), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
